// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and coordinate widths.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int ROW_W = 9;
    localparam int COL_W = 10;
    localparam int CNT_W = 10;

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register with per-bit synchronous reset value.
// DEPTH=0 degenerates to a wire.
module sync_delay #(
    parameter int                DEPTH   = 1,
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en_i};
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster counters for the VGA path: row/col for the overlay, pipelined de/syncs,
// and a value snapshot taken when pixel (0,0) is presented.
module vga_timing
    import vga_pkg::ROW_W, vga_pkg::COL_W, vga_pkg::CNT_W;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIPE     = 1,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [DATA_W-1:0] value,
    output logic [ROW_W-1:0]  curRow,
    output logic [COL_W-1:0]  curCol,
    output logic              active,
    output logic              de,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              frame_start,
    output logic [DATA_W-1:0] value_frame
);

    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              act_q, act_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic              fs_q, fs_d;
    logic [DATA_W-1:0] vf_q, vf_d;

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        row_d = row_q;
        col_d = col_q;
        act_d = act_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        fs_d  = 1'b0;
        vf_d  = vf_q;
        if (pix_en) begin
            act_d = (h_q < H_ACT_C) && (v_q < V_ACT_C);
            row_d = act_d ? v_q[ROW_W-1:0] : '0;
            col_d = act_d ? h_q[COL_W-1:0] : '0;
            hs_d  = !((h_q >= HS_START_C) && (h_q <= HS_END_C));
            vs_d  = !((v_q >= VS_START_C) && (v_q <= VS_END_C));
            fs_d  = (h_q == '0) && (v_q == '0);
            // Snapshot only at frame origin so the overlay never sees a torn value.
            if (fs_d) begin
                vf_d = value;
            end
            if (h_q == H_LAST_C) begin
                h_d = '0;
                v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            row_q <= '0;
            col_q <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
            vf_q  <= '0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            row_q <= row_d;
            col_q <= col_d;
            act_q <= act_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            vf_q  <= vf_d;
        end
    end

    // Delay matches the overlay's registered pixel path.
    sync_delay #(
        .DEPTH   (PIPE),
        .WIDTH   (3),
        .RST_VAL (3'b011)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_en),
        .d_i   ({act_q, hs_q, vs_q}),
        .q_o   ({de, hsync_n, vsync_n})
    );

    assign curRow      = row_q;
    assign curCol      = col_q;
    assign active      = act_q;
    assign frame_start = fs_q;
    assign value_frame = vf_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line-level boundaries, reduced-raster
// instance for whole-frame, vsync, snapshot and mid-frame reset behaviour.
module tb_vga_timing;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pipe;
    } cfg_t;

    typedef struct {
        logic [8:0] row;
        logic [9:0] col;
        logic       act, de, hs_n, vs_n;
    } exp_t;

    logic        clk, reset, pix_en;
    logic [15:0] value;

    logic [8:0]  d0_row, d1_row;
    logic [9:0]  d0_col, d1_col;
    logic        d0_act, d0_de, d0_hs, d0_vs, d0_fs;
    logic        d1_act, d1_de, d1_hs, d1_vs, d1_fs;
    logic [15:0] d0_vf, d1_vf;

    int          n_checks, n_fail;
    int          ticks;
    logic        fs0_exp, fs1_exp;
    logic [15:0] vf0_exp, vf1_exp;
    cfg_t        c0, c1;

    localparam int F0 = 420000;
    localparam int F1 = 195;

    vga_timing u_dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .value(value),
        .curRow(d0_row), .curCol(d0_col), .active(d0_act), .de(d0_de),
        .hsync_n(d0_hs), .vsync_n(d0_vs), .frame_start(d0_fs), .value_frame(d0_vf)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE(2), .DATA_W(16)
    ) u_dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .value(value),
        .curRow(d1_row), .curCol(d1_col), .active(d1_act), .de(d1_de),
        .hsync_n(d1_hs), .vsync_n(d1_vs), .frame_start(d1_fs), .value_frame(d1_vf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Expected outputs after k pixel ticks since reset, straight from raster arithmetic.
    function automatic exp_t expect_at(input cfg_t c, input int k);
        exp_t e;
        int ht, vt, p, h, v, kd;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        e.row = '0; e.col = '0; e.act = 1'b0; e.de = 1'b0; e.hs_n = 1'b1; e.vs_n = 1'b1;
        if (k >= 1) begin
            p = (k - 1) % (ht * vt); h = p % ht; v = p / ht;
            e.act = (h < c.ha) && (v < c.va);
            if (e.act) begin
                e.row = 9'(v);
                e.col = 10'(h);
            end
        end
        kd = k - c.pipe;
        if (kd >= 1) begin
            p = (kd - 1) % (ht * vt); h = p % ht; v = p / ht;
            e.de   = (h < c.ha) && (v < c.va);
            e.hs_n = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs));
            e.vs_n = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs));
        end
        return e;
    endfunction

    // One clk of stimulus plus model bookkeeping; returns 1 time unit after the edge.
    task automatic advance(input logic en, input logic rst);
        pix_en = en;
        reset  = rst;
        @(posedge clk);
        fs0_exp = 1'b0;
        fs1_exp = 1'b0;
        if (rst) begin
            ticks = 0; vf0_exp = '0; vf1_exp = '0;
        end else if (en) begin
            if (ticks % F0 == 0) begin vf0_exp = value; fs0_exp = 1'b1; end
            if (ticks % F1 == 0) begin vf1_exp = value; fs1_exp = 1'b1; end
            ticks++;
        end
        #1;
        pix_en = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        advance(1'b1, 1'b1);
        advance(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            advance(1'b0, 1'b0);
            n_checks++; if (d0_fs !== 1'b0) begin n_fail++; $display("FAIL reset_idle_fs0 clk %0d: got %b want 0", i, d0_fs); end
            n_checks++; if (d1_fs !== 1'b0) begin n_fail++; $display("FAIL reset_idle_fs1 clk %0d: got %b want 0", i, d1_fs); end
        end
        n_checks++; if ({d0_row, d0_col} !== 19'd0) begin n_fail++; $display("FAIL reset_rowcol0: got %0d/%0d want 0/0", d0_row, d0_col); end
        n_checks++; if ({d0_act, d0_de, d0_hs, d0_vs} !== 4'b0011) begin n_fail++; $display("FAIL reset_flags0: got %b want 0011", {d0_act, d0_de, d0_hs, d0_vs}); end
        n_checks++; if (d0_vf !== 16'h0) begin n_fail++; $display("FAIL reset_vf0: got %h want 0000", d0_vf); end
        n_checks++; if ({d1_row, d1_col} !== 19'd0) begin n_fail++; $display("FAIL reset_rowcol1: got %0d/%0d want 0/0", d1_row, d1_col); end
        n_checks++; if ({d1_act, d1_de, d1_hs, d1_vs} !== 4'b0011) begin n_fail++; $display("FAIL reset_flags1: got %b want 0011", {d1_act, d1_de, d1_hs, d1_vs}); end
        n_checks++; if (d1_vf !== 16'h0) begin n_fail++; $display("FAIL reset_vf1: got %h want 0000", d1_vf); end
    endtask

    task automatic test_line_boundaries();
        exp_t e;
        logic en, prev_hs;
        int   iter, low_cnt, fall_at, rise_at;
        value = 16'h0042;
        advance(1'b0, 1'b1);
        iter = 0; low_cnt = 0; fall_at = -1; rise_at = -1; prev_hs = 1'b1;
        while (ticks < 2400 && iter < 20000) begin
            en = ($urandom_range(0, 2) != 0);
            advance(en, 1'b0);
            iter++;
            e = expect_at(c0, ticks);
            n_checks++; if (d0_row !== e.row) begin n_fail++; $display("FAIL line_row tick %0d: got %0d want %0d", ticks, d0_row, e.row); end
            n_checks++; if (d0_col !== e.col) begin n_fail++; $display("FAIL line_col tick %0d: got %0d want %0d", ticks, d0_col, e.col); end
            n_checks++; if (d0_act !== e.act) begin n_fail++; $display("FAIL line_active tick %0d: got %b want %b", ticks, d0_act, e.act); end
            n_checks++; if (d0_de !== e.de) begin n_fail++; $display("FAIL line_de tick %0d: got %b want %b", ticks, d0_de, e.de); end
            n_checks++; if (d0_hs !== e.hs_n) begin n_fail++; $display("FAIL line_hsync tick %0d: got %b want %b", ticks, d0_hs, e.hs_n); end
            n_checks++; if (d0_vs !== e.vs_n) begin n_fail++; $display("FAIL line_vsync tick %0d: got %b want %b", ticks, d0_vs, e.vs_n); end
            n_checks++; if (d0_fs !== fs0_exp) begin n_fail++; $display("FAIL line_fs tick %0d: got %b want %b", ticks, d0_fs, fs0_exp); end
            if (en) begin
                if (d0_hs === 1'b0) low_cnt++;
                if (prev_hs === 1'b1 && d0_hs === 1'b0 && fall_at < 0) fall_at = ticks;
                if (prev_hs === 1'b0 && d0_hs === 1'b1 && rise_at < 0) rise_at = ticks;
                prev_hs = d0_hs;
                if (ticks == 1) begin
                    n_checks++; if ({d0_row, d0_col, d0_act, d0_fs} !== {9'd0, 10'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL first_tick: got row %0d col %0d act %b fs %b want 0 0 1 1", d0_row, d0_col, d0_act, d0_fs); end
                end
                if (ticks == 640) begin
                    n_checks++; if (d0_col !== 10'd639) begin n_fail++; $display("FAIL tick640_col: got %0d want 639", d0_col); end
                end
                if (ticks == 641) begin
                    n_checks++; if ({d0_act, d0_col} !== {1'b0, 10'd0}) begin n_fail++; $display("FAIL tick641: got act %b col %0d want 0 0", d0_act, d0_col); end
                end
            end
        end
        n_checks++; if (ticks < 2400) begin n_fail++; $display("FAIL line_budget: got %0d ticks want 2400", ticks); end
        n_checks++; if (fall_at !== 658) begin n_fail++; $display("FAIL hsync_fall: got tick %0d want 658", fall_at); end
        n_checks++; if (rise_at !== 754) begin n_fail++; $display("FAIL hsync_rise: got tick %0d want 754", rise_at); end
        n_checks++; if (low_cnt !== 288) begin n_fail++; $display("FAIL hsync_low_ticks: got %0d want 288", low_cnt); end
    endtask

    task automatic test_full_frame();
        exp_t e;
        logic en;
        int   iter, fs_cnt, last_fs, vs_low;
        advance(1'b0, 1'b1);
        iter = 0; fs_cnt = 0; last_fs = -1; vs_low = 0;
        while (ticks < 3 * F1 && iter < 5000) begin
            en = ($urandom_range(0, 2) != 0);
            value = 16'($urandom);
            advance(en, 1'b0);
            iter++;
            e = expect_at(c1, ticks);
            n_checks++; if ({d1_row, d1_col} !== {e.row, e.col}) begin n_fail++; $display("FAIL frame_rowcol tick %0d: got %0d/%0d want %0d/%0d", ticks, d1_row, d1_col, e.row, e.col); end
            n_checks++; if ({d1_act, d1_de} !== {e.act, e.de}) begin n_fail++; $display("FAIL frame_act_de tick %0d: got %b%b want %b%b", ticks, d1_act, d1_de, e.act, e.de); end
            n_checks++; if ({d1_hs, d1_vs} !== {e.hs_n, e.vs_n}) begin n_fail++; $display("FAIL frame_syncs tick %0d: got %b%b want %b%b", ticks, d1_hs, d1_vs, e.hs_n, e.vs_n); end
            n_checks++; if (d1_fs !== fs1_exp) begin n_fail++; $display("FAIL frame_fs tick %0d: got %b want %b", ticks, d1_fs, fs1_exp); end
            n_checks++; if (d1_vf !== vf1_exp) begin n_fail++; $display("FAIL frame_vf tick %0d: got %h want %h", ticks, d1_vf, vf1_exp); end
            if (d1_fs === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    n_checks++; if (ticks - last_fs !== F1) begin n_fail++; $display("FAIL fs_period: got %0d want %0d", ticks - last_fs, F1); end
                end
                last_fs = ticks;
            end
            if (en) begin
                if (d1_vs === 1'b0) vs_low++;
                if (ticks == 83) begin
                    n_checks++; if ({d1_act, d1_row, d1_col} !== {1'b1, 9'd5, 10'd7}) begin n_fail++; $display("FAIL last_active: got act %b row %0d col %0d want 1 5 7", d1_act, d1_row, d1_col); end
                end
                if (ticks == 84) begin
                    n_checks++; if (d1_act !== 1'b0) begin n_fail++; $display("FAIL after_last_active: got %b want 0", d1_act); end
                end
                if (ticks == F1 + 1) begin
                    n_checks++; if ({d1_act, d1_fs, d1_row, d1_col} !== {2'b11, 19'd0}) begin n_fail++; $display("FAIL frame_wrap: got act %b fs %b row %0d col %0d want 1 1 0 0", d1_act, d1_fs, d1_row, d1_col); end
                end
            end
        end
        n_checks++; if (fs_cnt !== 3) begin n_fail++; $display("FAIL fs_count: got %0d want 3", fs_cnt); end
        n_checks++; if (vs_low !== 90) begin n_fail++; $display("FAIL vsync_low_ticks: got %0d want 90", vs_low); end
    endtask

    task automatic test_value_frame();
        logic en;
        int   iter;
        advance(1'b0, 1'b1);
        value = 16'h1234;
        advance(1'b1, 1'b0);
        n_checks++; if (d1_vf !== 16'h1234) begin n_fail++; $display("FAIL vf_first: got %h want 1234", d1_vf); end
        iter = 0;
        while (ticks < F1 && iter < 2000) begin
            if (ticks >= 60) value = 16'hABCD;
            en = ($urandom_range(0, 1) != 0);
            advance(en, 1'b0);
            iter++;
            n_checks++; if (d1_vf !== 16'h1234) begin n_fail++; $display("FAIL vf_hold tick %0d: got %h want 1234", ticks, d1_vf); end
        end
        advance(1'b1, 1'b0);
        n_checks++; if ({d1_fs, d1_vf} !== {1'b1, 16'hABCD}) begin n_fail++; $display("FAIL vf_next_frame: got fs %b vf %h want 1 abcd", d1_fs, d1_vf); end
        iter = 0;
        while (ticks < 2 * F1 + 20 && iter < 2000) begin
            value = 16'($urandom);
            advance(1'b1, 1'b0);
            iter++;
            n_checks++; if (d1_vf !== vf1_exp) begin n_fail++; $display("FAIL vf_random tick %0d: got %h want %h", ticks, d1_vf, vf1_exp); end
            n_checks++; if (d0_vf !== vf0_exp) begin n_fail++; $display("FAIL vf0_random tick %0d: got %h want %h", ticks, d0_vf, vf0_exp); end
        end
    endtask

    task automatic test_reset_mid_frame();
        advance(1'b0, 1'b1);
        value = 16'h5A5A;
        for (int i = 0; i < 51; i++) advance(1'b1, 1'b0);
        n_checks++; if ({d1_row, d1_col, d1_vf} !== {9'd3, 10'd5, 16'h5A5A}) begin n_fail++; $display("FAIL mid_position: got row %0d col %0d vf %h want 3 5 5a5a", d1_row, d1_col, d1_vf); end
        advance(1'b1, 1'b1);
        n_checks++; if ({d1_row, d1_col, d1_act, d1_de, d1_hs, d1_vs, d1_fs, d1_vf} !== {19'd0, 5'b00110, 16'h0}) begin n_fail++; $display("FAIL mid_reset1: got row %0d col %0d flags %b vf %h", d1_row, d1_col, {d1_act, d1_de, d1_hs, d1_vs, d1_fs}, d1_vf); end
        n_checks++; if ({d0_row, d0_col, d0_act, d0_de, d0_hs, d0_vs, d0_fs, d0_vf} !== {19'd0, 5'b00110, 16'h0}) begin n_fail++; $display("FAIL mid_reset0: got row %0d col %0d flags %b vf %h", d0_row, d0_col, {d0_act, d0_de, d0_hs, d0_vs, d0_fs}, d0_vf); end
        advance(1'b0, 1'b0);
        n_checks++; if ({d1_act, d1_fs} !== 2'b00) begin n_fail++; $display("FAIL mid_idle: got act %b fs %b want 0 0", d1_act, d1_fs); end
        advance(1'b1, 1'b0);
        n_checks++; if ({d1_row, d1_col, d1_act, d1_fs, d1_de} !== {19'd0, 3'b110}) begin n_fail++; $display("FAIL mid_restart1: got row %0d col %0d act %b fs %b de %b", d1_row, d1_col, d1_act, d1_fs, d1_de); end
        n_checks++; if ({d0_act, d0_fs, d0_vf} !== {2'b11, 16'h5A5A}) begin n_fail++; $display("FAIL mid_restart0: got act %b fs %b vf %h", d0_act, d0_fs, d0_vf); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ticks = 0;
        fs0_exp = 1'b0; fs1_exp = 1'b0; vf0_exp = '0; vf1_exp = '0;
        reset = 1'b0; pix_en = 1'b0; value = '0;
        c0 = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33, pipe: 1};
        c1 = '{ha: 8, hfp: 2, hs: 3, hbp: 2, va: 6, vfp: 2, vs: 2, vbp: 3, pipe: 2};
        test_reset();
        test_line_boundaries();
        test_full_frame();
        test_value_frame();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480@60 Hz VGA path. Advances horizontal and vertical counters on each pixel-clock enable. Feeds the text/number overlay stage with the current row and column. Emits the display-enable and sync signals, delayed to line up with the overlay's registered pixel, and captures a tear-free, once-per-frame snapshot of the value to be displayed.

## Interface
Parameters:
- H_ACTIVE, 640, visible columns
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- PIPE, 1, pixel ticks of delay on hsync_n/vsync_n/de (0..4)
- DATA_W, 16, width of displayed value (4 bits per digit)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel tick; one clk cycle wide, nominally every 2nd clk
- value  in  DATA_W  live value to display
- curRow  out  9  current visible row; 0 outside active area
- curCol  out  10  current visible column; 0 outside active area
- active  out  1  current (curRow, curCol) is visible, undelayed
- de  out  1  active delayed by PIPE ticks
- hsync_n  out  1  horizontal sync, active-low, delayed by PIPE ticks
- vsync_n  out  1  vertical sync, active-low, delayed by PIPE ticks
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented
- value_frame  out  DATA_W  value sampled at frame_start, stable for the whole frame

## Operation
- Internal counters: h 0..H_TOTAL-1 (800) and v 0..V_TOTAL-1 (525), both 10 bits wide.
- On a pix_en tick:
  - outputs load the decode of the current (h,v);
  - h increments; at 799, h wraps to 0 and v increments; at v=524 with h=799, both wrap to 0.
- Decode:
  - active = h<640 && v<480.
  - curCol = active ? h : 0; curRow = active ? v[8:0] : 0.
  - raw hsync_n is 0 iff 656 ≤ h ≤ 751.
  - raw vsync_n is 0 iff 490 ≤ v ≤ 491.
- With pix_en low, every register holds and frame_start is 0.
- frame_start is 1 for exactly the clk cycle whose tick loads (h,v)=(0,0). value_frame loads value on that same tick; a value change mid-frame is not visible until the next frame.
- Delay line: active, raw hsync_n and raw vsync_n shift through PIPE pix_en-gated stages to give de, hsync_n and vsync_n. With PIPE=0 they equal the undelayed decode.
- Reset (any time, including mid-frame):
  - h=v=0;
  - curRow=0, curCol=0, active=0, de=0;
  - hsync_n=1, vsync_n=1 (including all delay stages);
  - frame_start=0, value_frame=0.
- The first pix_en after reset presents (0,0) with active=1 and frame_start=1.

## Timing
- Latency from counter state to outputs is 1 clk, on the tick.
- de, hsync_n and vsync_n lag curRow/curCol/active by PIPE ticks.
- Frame period is 420000 ticks (840000 clk at pix_en = clk/2). Line period is 800 ticks.
- pix_en asserted on consecutive clks is legal; it only changes the rate.
- reset has priority over a coincident pix_en.

## Structure
- Shared package vga_pkg holds:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL, HS_START/HS_END, VS_START/VS_END;
  - coordinate widths (ROW_W=9, COL_W=10).
- Sub-module sync_delay: parameterised depth and width, enable-gated shift register with synchronous reset to a per-bit reset value. It is instantiated once for {de, hsync_n, vsync_n}.

## Test plan
- Reset, then hold pix_en=0 for 10 clk: all outputs at reset values.
- Reset, then pix_en every 2nd clk. Required:
  - first tick: curCol=0, curRow=0, active=1, frame_start=1;
  - tick 640: curCol=639;
  - tick 641: active=0, curCol=0.
- PIPE=1:
  - hsync_n falls on the tick after h=656 is decoded and rises after h=751: 96 ticks low per line;
  - vsync_n is low for exactly 1600 ticks, covering lines 490-491.
- Full frame: frame_start pulses exactly once per 420000 ticks. Row 479 col 639 is the last active pixel, and the tick after v=524,h=799 presents (0,0).
- Apply value=16'h1234 at frame_start, then change it to 16'hABCD mid-frame: value_frame stays 16'h1234 until the next frame_start, then becomes 16'hABCD.
- Assert reset at row 300 col 100, concurrent with pix_en: outputs return to reset values next clk, and the next tick restarts at (0,0) with frame_start=1.
